// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and status register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned BAUD_W         = 16;
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_IRQ_EN    = 4;
    localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is kept
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Bus-attached 8N1 UART transmitter with a transmit FIFO, status register
// and an active-low "transmitter drained" interrupt.
module uart_tx_peripheral #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic        data_reg_select,
    input  logic        status_reg_select,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        UART_Tx,
    output logic        irq_tx_empty_L
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              baud_done;

    logic              armed_q;
    logic              overflow_q;
    logic              irq_en_q;
    logic              irq_q;

    logic              wr_access, act, data_wr, stat_wr, stat_rd, drop;
    logic [7:0]        fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_bits;

    assign unused_bits = ^{data_in[31:8], data_in[7:5], data_in[2:0]};

    // Bus decode: one action per strobe, re-armed once AS_L returns high.
    assign wr_access = (data_reg_select || status_reg_select) && !AS_L && !WE_L;
    assign act       = wr_access && armed_q;
    assign data_wr   = act && data_reg_select;
    assign stat_wr   = act && status_reg_select;
    assign drop      = data_wr && fifo_full && !pop;
    assign stat_rd   = status_reg_select && !AS_L && WE_L && !Reset;
    assign baud_done = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (data_wr),
        .pop   (pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transmit FSM next-state, baud/bit counters and next serial level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // FSM state register; serial line registered from next-state values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Bus-side registers: re-arm, sticky overflow, irq enable, interrupt.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            armed_q    <= 1'b1;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b1;
        end else begin
            if (AS_L)     armed_q <= 1'b1;
            else if (act) armed_q <= 1'b0;
            if (drop)                       overflow_q <= 1'b1;
            else if (stat_wr && data_in[3]) overflow_q <= 1'b0;
            if (stat_wr) irq_en_q <= data_in[4];
            irq_q <= ~(irq_en_q && fifo_empty && (state_q == IDLE));
        end
    end

    // Combinational status read; zero whenever no status read is in progress.
    always_comb begin
        data_out = '0;
        if (stat_rd) begin
            data_out[STAT_BUSY]                       = (state_q != IDLE);
            data_out[STAT_FULL]                       = fifo_full;
            data_out[STAT_EMPTY]                      = fifo_empty;
            data_out[STAT_OVERFLOW]                   = overflow_q;
            data_out[STAT_IRQ_EN]                     = irq_en_q;
            data_out[STAT_COUNT_LSB+7:STAT_COUNT_LSB] = 8'(fifo_count);
        end
    end

    assign UART_Tx        = tx_q;
    assign irq_tx_empty_L = irq_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_peripheral;

    logic        Clock;
    logic        Reset;
    logic        AS_L;
    logic        WE_L;
    logic        data_reg_select;
    logic        status_reg_select;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        UART_Tx;
    logic        irq_tx_empty_L;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames_done = 0;
    int last_end = 0;
    int w_cyc = 0;
    int starts[$];
    logic [7:0] exp_q[$];
    logic [39:0] mon_line;
    logic [39:0] mon_wave;
    logic [7:0]  mon_exp;
    logic [7:0]  mon_rx;
    int          mon_st;
    bit          mon_abort;

    typedef struct {
        logic        as_l;
        logic        we_l;
        logic        dsel;
        logic        ssel;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;
    vec_t tbl[13];

    uart_tx_peripheral #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .AS_L              (AS_L),
        .WE_L              (WE_L),
        .data_reg_select   (data_reg_select),
        .status_reg_select (status_reg_select),
        .data_in           (data_in),
        .data_out          (data_out),
        .UART_Tx           (UART_Tx),
        .irq_tx_empty_L    (irq_tx_empty_L)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_idle();
        AS_L = 1'b1; WE_L = 1'b1; data_reg_select = 1'b0; status_reg_select = 1'b0;
    endtask

    task automatic bus_write(input logic is_data, input logic [31:0] val);
        @(negedge Clock);
        AS_L = 1'b0; WE_L = 1'b0; data_in = val;
        data_reg_select = is_data; status_reg_select = !is_data;
        w_cyc = cyc;
        @(negedge Clock);
        bus_idle();
    endtask

    task automatic sread(input string name, input logic [31:0] exp);
        @(negedge Clock);
        AS_L = 1'b0; WE_L = 1'b1; status_reg_select = 1'b1; data_reg_select = 1'b0;
        #1 check(name, data_out, exp);
        @(negedge Clock);
        bus_idle();
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge Clock);
            k++;
        end
        total++;
        if (frames_done < target) begin
            bad++;
            $display("FAIL frame_timeout: got %0d frames want %0d", frames_done, target);
        end
    endtask

    // Serial line monitor: captures 40 cycles per frame, compares with scoreboard.
    initial begin : monitor
        forever begin
            @(negedge Clock);
            if (!Reset && UART_Tx === 1'b0) begin
                mon_st = cyc;
                mon_line = '0;
                mon_abort = 1'b0;
                for (int c = 1; c < 40; c++) begin
                    @(negedge Clock);
                    if (Reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_line[c] = UART_Tx;
                end
                if (!mon_abort) begin
                    starts.push_back(mon_st);
                    last_end = cyc;
                    for (int i = 0; i < 8; i++) mon_rx[i] = mon_line[4 + 4*i + 2];
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got byte %h want no frame", mon_rx);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        for (int c = 0; c < 40; c++)
                            mon_wave[c] = (c < 4) ? 1'b0 : (c < 36) ? mon_exp[(c-4)/4] : 1'b1;
                        check("frame_wave", {mon_rx, 32'(mon_line[31:0] ^ mon_wave[31:0])},
                              {mon_exp, 32'h0});
                        check("frame_tail", 32'(mon_line[39:32]), 32'(mon_wave[39:32]));
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : stim
        int base;
        int w0;
        bus_idle();
        data_in = '0;
        Reset = 1'b1;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0014, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00EF, 32'h0000_0000, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0014, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};

        // Reset outputs, with a status read attempted during reset.
        @(negedge Clock);
        AS_L = 1'b0; status_reg_select = 1'b1;
        @(negedge Clock);
        check("rst_tx", 32'(UART_Tx), 32'd1);
        check("rst_irq", 32'(irq_tx_empty_L), 32'd1);
        check("rst_dout", data_out, 32'h0);
        Reset = 1'b0;
        bus_idle();
        @(negedge Clock);

        // Register-level vectors.
        foreach (tbl[i]) begin
            @(negedge Clock);
            AS_L = tbl[i].as_l; WE_L = tbl[i].we_l;
            data_reg_select = tbl[i].dsel; status_reg_select = tbl[i].ssel;
            data_in = tbl[i].wdata;
            #1;
            check($sformatf("vec%0d_dout", i), data_out, tbl[i].exp_dout);
            check($sformatf("vec%0d_irq", i), 32'(irq_tx_empty_L), 32'(tbl[i].exp_irq));
            @(negedge Clock);
            bus_idle();
        end

        // Single byte 0x55: latency and full frame shape.
        base = frames_done;
        starts.delete();
        exp_q.push_back(8'h55);
        bus_write(1'b1, 32'h55);
        w0 = w_cyc;
        wait_frames(base + 1, 200);
        if (starts.size() > 0) check("latency", 32'(starts[0] - w0), 32'd2);
        sread("after_55", 32'h0000_0004);

        // Strobe held low for five cycles: exactly one push.
        base = frames_done;
        exp_q.push_back(8'hA5);
        @(negedge Clock);
        AS_L = 1'b0; WE_L = 1'b0; data_reg_select = 1'b1; data_in = 32'hA5;
        repeat (5) @(negedge Clock);
        bus_idle();
        sread("hold_status", 32'h0000_0005);
        wait_frames(base + 1, 200);
        repeat (50) @(negedge Clock);
        check("hold_frames", 32'(frames_done), 32'(base + 1));

        // Interrupt behaviour around one frame.
        bus_write(1'b0, 32'h10);
        @(negedge Clock);
        check("irq_low_idle", 32'(irq_tx_empty_L), 32'd0);
        base = frames_done;
        exp_q.push_back(8'h33);
        bus_write(1'b1, 32'h33);
        @(negedge Clock);
        check("irq_high_busy", 32'(irq_tx_empty_L), 32'd1);
        wait_frames(base + 1, 200);
        while (cyc < last_end + 1) @(negedge Clock);
        check("irq_stop_lag", 32'(irq_tx_empty_L), 32'd1);
        @(negedge Clock);
        check("irq_low_after", 32'(irq_tx_empty_L), 32'd0);

        // Six writes: fill, overflow, contiguous frames, overflow clear.
        base = frames_done;
        starts.delete();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            bus_write(1'b1, 32'(i));
        end
        sread("full_status", 32'h0000_0413);
        @(negedge Clock);
        AS_L = 1'b1; WE_L = 1'b1; status_reg_select = 1'b1;
        #1 check("no_strobe_dout", data_out, 32'h0);
        bus_write(1'b1, 32'h06);
        sread("ovf_status", 32'h0000_041B);
        bus_write(1'b0, 32'h08);
        sread("ovf_cleared", 32'h0000_0403);
        wait_frames(base + 5, 400);
        for (int i = 0; i < 4; i++)
            if (starts.size() > i + 1)
                check($sformatf("gap%0d", i), 32'(starts[i+1] - starts[i]), 32'd40);
        sread("drained", 32'h0000_0004);

        // Reset during data bit 3 of 0xF0 with two bytes queued.
        base = frames_done;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        bus_write(1'b1, 32'hF0);
        w0 = w_cyc;
        bus_write(1'b1, 32'h11);
        bus_write(1'b1, 32'h22);
        while (cyc < w0 + 19) @(negedge Clock);
        Reset = 1'b1;
        AS_L = 1'b0; WE_L = 1'b1; status_reg_select = 1'b1;
        @(negedge Clock);
        check("midrst_tx", 32'(UART_Tx), 32'd1);
        check("midrst_irq", 32'(irq_tx_empty_L), 32'd1);
        check("midrst_dout", data_out, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        bus_idle();
        exp_q.delete();
        sread("post_rst_status", 32'h0000_0004);
        repeat (150) @(negedge Clock);
        check("post_rst_frames", 32'(frames_done), 32'(base));
        check("post_rst_tx", 32'(UART_Tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_peripheral.md
UART_TX_PERIPHERAL -- requirements
Module: uart_tx_peripheral

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..256.
REQ-003 Clock  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 AS_L  input  1  bus address strobe, active low.
REQ-006 WE_L  input  1  bus write enable, active low (high = read).
REQ-007 data_reg_select  input  1  decoded select for TX data register, from IO decode.
REQ-008 status_reg_select  input  1  decoded select for status/control register.
REQ-009 data_in  input  32  bus write data; [7:0] used for data register.
REQ-010 data_out  output  32  bus read data.
REQ-011 UART_Tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-012 irq_tx_empty_L  output  1  active-low interrupt, FIFO empty and transmitter idle.

Function
REQ-013 Write access = select && !AS_L && !WE_L; exactly one action per access: act on first cycle only, re-armed after AS_L high for at least one cycle.
REQ-014 Data write pushes data_in[7:0] to FIFO; accepted if count < FIFO_DEPTH or pop occurs same cycle; otherwise dropped and overflow sticky bit set.
REQ-015 Status write: data_in[4] loads irq_enable; data_in[3]=1 clears overflow; other bits ignored.
REQ-016 Status read (status_reg_select && !AS_L && WE_L) drives data_out combinationally: [0] busy (state != IDLE), [1] full, [2] empty, [3] overflow, [4] irq_enable, [15:8] FIFO count, rest 0.
REQ-017 data_out = 0 whenever no status read in progress; data register reads return 0.
REQ-018 FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: UART_Tx=1; if FIFO non-empty, pop head into shift register and enter START next cycle.
REQ-020 START: UART_Tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits, bit 0 first, each exactly CLKS_PER_BIT cycles; 3-bit index; after bit 7 enter STOP.
REQ-022 STOP: UART_Tx=1 for CLKS_PER_BIT cycles; on its last cycle, if FIFO non-empty pop and enter START (no idle gap), else IDLE.
REQ-023 Latency: write accepted in cycle N into empty FIFO with FSM IDLE -> UART_Tx low from cycle N+2.
REQ-024 Baud counter 16 bits, counts 0..CLKS_PER_BIT-1, cleared on every state entry.
REQ-025 Simultaneous push and pop: count unchanged; order preserved, FIFO wraps pointers modulo FIFO_DEPTH.
REQ-026 irq_tx_empty_L = !(irq_enable && empty && state==IDLE), registered, one-cycle lag.
REQ-027 Status writes never disturb an in-flight frame or FIFO contents.

Reset
REQ-028 Reset while asserted: state IDLE, FIFO emptied, counters 0, overflow 0, irq_enable 0, write re-arm set.
REQ-029 Outputs under reset: UART_Tx=1, irq_tx_empty_L=1, data_out=0.
REQ-030 Reset mid-frame aborts frame; UART_Tx high in cycle after reset edge; queued bytes discarded.

Structure
REQ-031 Package uart_pkg holds state enum (IDLE, START, DATA, STOP) and status bit-position constants; shared with a later RX block.
REQ-032 Single sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); FSM, baud counter, bus logic in top.
REQ-033 IO decode supplies data_reg_select/status_reg_select; block performs no address decoding.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 0x55 in cycle N -> UART_Tx low N+2..N+5, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, busy clears.
REQ-035 Write 0xA5 with AS_L held low 5 cycles -> exactly one byte transmitted, count never exceeds 1.
REQ-036 Six back-to-back writes 0x01..0x06 -> 0x01..0x05 sent (one popped, four queued), 0x06 dropped, overflow=1; frames contiguous, no idle gap; status write 0x08 clears overflow.
REQ-037 Status write 0x10, FIFO empty, idle -> irq_tx_empty_L low; write 0x33 -> irq high within 2 cycles, low again one cycle after STOP completes.
REQ-038 Reset asserted during DATA bit 3 of 0xF0 with 2 bytes queued -> UART_Tx=1, status reads 0x00000004, no further frames.
REQ-039 Status read with full FIFO -> data_out[15:8]=4, [1]=1, [2]=0; data_out=0 when AS_L high.
